// File: rtl/traffic_phase_scheduler_pkg.sv
// ============================================================================
// traffic_phase_scheduler_pkg : lamp codes, phase encoding and sizing helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package traffic_phase_scheduler_pkg;

  typedef enum logic [1:0] {
    LAMP_RED    = 2'd0,
    LAMP_YELLOW = 2'd1,
    LAMP_GREEN  = 2'd2
  } lamp_e;

  typedef enum logic [2:0] {
    ST_HG  = 3'd0,
    ST_HY  = 3'd1,
    ST_AR1 = 3'd2,
    ST_CG  = 3'd3,
    ST_CY  = 3'd4,
    ST_AR2 = 3'd5,
    ST_PW  = 3'd6
  } state_e;

  function automatic int max_ticks(input int a, input int b, input int c,
                                   input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_phase_scheduler_timer.sv
// ============================================================================
// traffic_phase_scheduler_timer : saturating up-counter, sync clear, async reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module traffic_phase_scheduler_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (r_count != {WIDTH{1'b1}}) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
// ============================================================================
// traffic_phase_scheduler : timed highway/country/pedestrian phase sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module traffic_phase_scheduler
  import traffic_phase_scheduler_pkg::*;
#(
  parameter int HWY_MIN_GREEN   = 8,
  parameter int CNTRY_MAX_GREEN = 6,
  parameter int YELLOW_TICKS    = 2,
  parameter int ALLRED_TICKS    = 1,
  parameter int WALK_TICKS      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  input  logic       ped_req,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic [2:0] phase
);

  localparam int TW = $clog2(max_ticks(HWY_MIN_GREEN, CNTRY_MAX_GREEN, YELLOW_TICKS,
                                       ALLRED_TICKS, WALK_TICKS)) + 1;

  localparam logic [TW-1:0] C_HG_LAST   = TW'(HWY_MIN_GREEN - 1);
  localparam logic [TW-1:0] C_CG_LAST   = TW'(CNTRY_MAX_GREEN - 1);
  localparam logic [TW-1:0] C_YEL_LAST  = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] C_AR_LAST   = TW'(ALLRED_TICKS - 1);
  localparam logic [TW-1:0] C_WALK_LAST = TW'(WALK_TICKS - 1);

  state_e          r_state;
  state_e          w_next;
  logic            r_ped_pend;
  logic            w_ped_next;
  logic            w_state_chg;
  logic [TW-1:0]   w_timer;

  assign w_state_chg = (w_next != r_state);

  traffic_phase_scheduler_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk     (clk),
    .rst     (reset),
    .i_clr   (w_state_chg),
    .o_count (w_timer)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_HG;
      r_ped_pend <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ped_pend <= w_ped_next;
    end
  end

  // Dwell comparisons use >= so a saturated timer can never strand a phase.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HG:  if ((w_timer >= C_HG_LAST) && (x || r_ped_pend)) w_next = ST_HY;
      ST_HY:  if (w_timer >= C_YEL_LAST) w_next = ST_AR1;
      ST_AR1: if (w_timer >= C_AR_LAST) begin
                if (x)               w_next = ST_CG;
                else if (r_ped_pend) w_next = ST_PW;
                else                 w_next = ST_HG;
              end
      ST_CG:  if (!x || (w_timer >= C_CG_LAST)) w_next = ST_CY;
      ST_CY:  if (w_timer >= C_YEL_LAST) w_next = ST_AR2;
      ST_AR2: if (w_timer >= C_AR_LAST) w_next = r_ped_pend ? ST_PW : ST_HG;
      ST_PW:  if (w_timer >= C_WALK_LAST) w_next = ST_HG;
      default: w_next = ST_HG;
    endcase
  end

  // Entering the walk phase serves the request, overriding a same-cycle press.
  always_comb begin
    w_ped_next = r_ped_pend | ped_req;
    if ((w_next == ST_PW) && (r_state != ST_PW)) w_ped_next = 1'b0;
  end

  always_comb begin
    hwy   = LAMP_RED;
    cntry = LAMP_RED;
    walk  = 1'b0;
    case (r_state)
      ST_HG: hwy   = LAMP_GREEN;
      ST_HY: hwy   = LAMP_YELLOW;
      ST_CG: cntry = LAMP_GREEN;
      ST_CY: cntry = LAMP_YELLOW;
      ST_PW: walk  = 1'b1;
      default: ;
    endcase
  end

  assign phase = r_state;

endmodule

`default_nettype wire
